// File: rtl/i2c_tx_sequencer.sv
// i2c_tx_sequencer
//   Feeds the i2c_master command and data AXI-stream channels from the
//   send-buffer FIFO. A start request issues one write-multiple command to a
//   7-bit device address, then streams exactly `len` bytes from the FIFO with
//   tlast on the final byte. Once the bus goes idle it pulses done, with err
//   set if the master reported a missed ACK during the burst.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   start, dev_addr, len : burst request (len == 0 is ignored)
//   fifo_data/have_next  : FIFO head byte and non-empty flag
//   fifo_next            : FIFO pop strobe (head consumed this cycle)
//   cmd_*                : command channel towards the master
//   data_*               : data channel towards the master
//   i2c_busy, missed_ack : status from the master
//   busy, done, err      : sequencer status (err is sticky until next start)
module i2c_tx_sequencer #(
  parameter int LenWidth = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [6:0]          dev_addr,
  input  logic [LenWidth-1:0] len,
  input  logic [7:0]          fifo_data,
  input  logic                fifo_have_next,
  output logic                fifo_next,
  output logic [6:0]          cmd_address,
  output logic                cmd_valid,
  output logic                cmd_write_multiple,
  input  logic                cmd_ready,
  output logic [7:0]          data_tdata,
  output logic                data_tvalid,
  output logic                data_tlast,
  input  logic                data_tready,
  input  logic                i2c_busy,
  input  logic                missed_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CMD       = 2'd1,
    DATA      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_reg;
  logic [6:0]          addr_reg;
  logic [LenWidth-1:0] rem_reg;
  logic [7:0]          buf_reg;
  logic                buf_v_reg;
  logic                last_reg;
  logic                err_reg;

  logic in_data;
  logic handshake;
  logic load;

  assign in_data   = (state_reg == DATA);
  assign handshake = in_data && buf_v_reg && data_tready;

  // The single-entry buffer refills either when empty or in the same cycle
  // its current byte is taken (but never past the final byte). A missed ACK
  // blocks the pop so unsent bytes remain in the FIFO.
  assign load = in_data && !missed_ack && (rem_reg != '0) && fifo_have_next &&
                (!buf_v_reg || (data_tready && !last_reg));

  assign fifo_next          = load;
  assign cmd_address        = addr_reg;
  assign cmd_valid          = (state_reg == CMD);
  assign cmd_write_multiple = (state_reg == CMD);
  assign data_tdata         = buf_reg;
  assign data_tvalid        = buf_v_reg;
  assign data_tlast         = buf_v_reg && last_reg;
  assign busy               = (state_reg != IDLE);
  // done is decoded while still in WAIT_DONE so busy falls one cycle later.
  assign done               = (state_reg == WAIT_DONE) && !i2c_busy;
  assign err                = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      buf_reg   <= '0;
      buf_v_reg <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && (len != '0)) begin
            addr_reg  <= dev_addr;
            rem_reg   <= len;
            err_reg   <= 1'b0;
            buf_v_reg <= 1'b0;
            last_reg  <= 1'b0;
            state_reg <= CMD;
          end
        end
        CMD: begin
          if (missed_ack) begin
            err_reg   <= 1'b1;
            state_reg <= WAIT_DONE;
          end else if (cmd_ready) begin
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (missed_ack) begin
            err_reg   <= 1'b1;
            buf_v_reg <= 1'b0;
            state_reg <= WAIT_DONE;
          end else begin
            if (load) begin
              buf_reg   <= fifo_data;
              buf_v_reg <= 1'b1;
              last_reg  <= (rem_reg == LenWidth'(1));
              rem_reg   <= rem_reg - LenWidth'(1);
            end else if (handshake) begin
              buf_v_reg <= 1'b0;
            end
            if (handshake && last_reg) begin
              state_reg <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (missed_ack) begin
            err_reg <= 1'b1;
          end
          if (!i2c_busy) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
module tb_i2c_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] dev_addr;
  logic [7:0] len;
  logic [7:0] fifo_data;
  logic       fifo_have_next;
  logic       fifo_next;
  logic [6:0] cmd_address;
  logic       cmd_valid;
  logic       cmd_write_multiple;
  logic       cmd_ready;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tlast;
  logic       data_tready;
  logic       i2c_busy;
  logic       missed_ack;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  i2c_tx_sequencer #(.LenWidth(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .dev_addr           (dev_addr),
    .len                (len),
    .fifo_data          (fifo_data),
    .fifo_have_next     (fifo_have_next),
    .fifo_next          (fifo_next),
    .cmd_address        (cmd_address),
    .cmd_valid          (cmd_valid),
    .cmd_write_multiple (cmd_write_multiple),
    .cmd_ready          (cmd_ready),
    .data_tdata         (data_tdata),
    .data_tvalid        (data_tvalid),
    .data_tlast         (data_tlast),
    .data_tready        (data_tready),
    .i2c_busy           (i2c_busy),
    .missed_ack         (missed_ack),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  // FIFO model: pushes come from the stimulus process, pops from the DUT.
  logic [7:0] fifo_mem [64];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  assign fifo_data      = fifo_mem[rd_ptr];
  assign fifo_have_next = (wr_ptr != rd_ptr);
  always_ff @(posedge clk) begin
    if (fifo_next) rd_ptr <= rd_ptr + 6'd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  int         cmd_n, rx_n, pop_n, done_n;
  logic [6:0] cmd_addr_seen;
  logic       cmd_wm_seen;
  logic [7:0] rx_data [16];
  logic       rx_last [16];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (cmd_valid && cmd_ready) begin
      cmd_n++;
      cmd_addr_seen = cmd_address;
      cmd_wm_seen   = cmd_write_multiple;
      $display("cmd  addr=%02h write_multiple=%b", cmd_address, cmd_write_multiple);
    end
    if (data_tvalid && data_tready) begin
      if (rx_n < 16) begin
        rx_data[rx_n] = data_tdata;
        rx_last[rx_n] = data_tlast;
      end
      rx_n++;
      $display("data byte=%02h last=%b", data_tdata, data_tlast);
    end
    if (fifo_next) begin
      pop_n++;
      check("pop_nonempty", fifo_have_next, 1);
    end
    if (done) done_n++;
    if (stall_prev) begin
      check("stall_tvalid", data_tvalid, 1);
      check("stall_tdata", data_tdata, prev_data);
      check("stall_tlast", data_tlast, prev_last);
    end
    stall_prev = data_tvalid && !data_tready;
    prev_data  = data_tdata;
    prev_last  = data_tlast;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cmd_n = 0; rx_n = 0; pop_n = 0; done_n = 0;
    cmd_addr_seen = '0; cmd_wm_seen = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_start(input logic [6:0] a, input logic [7:0] l);
    start = 1'b1; dev_addr = a; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic cmd_handshake();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 200; k++) begin
      if (rx_n >= n) break;
      tick();
    end
    check("rx_count", rx_n, n);
  endtask

  task automatic finish_bus();
    i2c_busy = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("busy_with_done", busy, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    i2c_busy = 1'b1;
    check("done_count", done_n, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dev_addr = '0; len = '0;
    cmd_ready = 1'b0; data_tready = 1'b1; i2c_busy = 1'b1; missed_ack = 1'b0;
    clr();
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_wm", cmd_write_multiple, 0);
    check("rst_tvalid", data_tvalid, 0);
    check("rst_tlast", data_tlast, 0);
    check("rst_fifo_next", fifo_next, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", cmd_address, 0);
    check("rst_tdata", data_tdata, 0);
    reset = 1'b0;
    tick();

    // Normal burst
    clr();
    push(8'hA1); push(8'hB2); push(8'hC3);
    do_start(7'h27, 8'd3);
    check("n_cmd_valid", cmd_valid, 1);
    check("n_busy", busy, 1);
    check("n_cmd_addr", cmd_address, 7'h27);
    check("n_cmd_wm", cmd_write_multiple, 1);
    tick(); tick();
    check("n_cmd_hold", cmd_valid, 1);
    cmd_handshake();
    check("n_first_pop", fifo_next, 1);
    check("n_first_tvalid", data_tvalid, 0);
    for (int i = 0; i < 4; i++) tick();
    check("n_throughput", rx_n, 3);
    check("n_cmds", cmd_n, 1);
    check("n_cmd_addr_seen", cmd_addr_seen, 7'h27);
    check("n_cmd_wm_seen", cmd_wm_seen, 1);
    check("n_b0", rx_data[0], 8'hA1);
    check("n_b1", rx_data[1], 8'hB2);
    check("n_b2", rx_data[2], 8'hC3);
    check("n_l0", rx_last[0], 0);
    check("n_l1", rx_last[1], 0);
    check("n_l2", rx_last[2], 1);
    check("n_pops", pop_n, 3);
    check("n_tvalid_wait", data_tvalid, 0);
    finish_bus();
    check("n_err", err, 0);

    // Backpressure
    clr();
    push(8'h11); push(8'h22);
    data_tready = 1'b0;
    do_start(7'h3A, 8'd2);
    cmd_handshake();
    for (int k = 0; k < 60; k++) begin
      if (rx_n >= 2) break;
      data_tready = ((k % 4) == 3);
      tick();
    end
    check("bp_rx", rx_n, 2);
    check("bp_b0", rx_data[0], 8'h11);
    check("bp_b1", rx_data[1], 8'h22);
    check("bp_l0", rx_last[0], 0);
    check("bp_l1", rx_last[1], 1);
    check("bp_pops", pop_n, 2);
    data_tready = 1'b1;
    finish_bus();

    // Zero-length start
    clr();
    do_start(7'h12, 8'd0);
    check("z_busy", busy, 0);
    tick(); tick(); tick();
    check("z_busy_later", busy, 0);
    check("z_cmd_valid", cmd_valid, 0);
    check("z_done", done_n, 0);

    // Underflow stall with a start request issued mid-burst
    clr();
    push(8'h5A);
    do_start(7'h33, 8'd3);
    cmd_handshake();
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        start = 1'b1; dev_addr = 7'h11; len = 8'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("u_rx_gap", rx_n, 1);
    check("u_pops_gap", pop_n, 1);
    check("u_tvalid_gap", data_tvalid, 0);
    check("u_busy_gap", busy, 1);
    check("u_addr_kept", cmd_address, 7'h33);
    push(8'h6B); push(8'h7C);
    wait_rx(3);
    check("u_b1", rx_data[1], 8'h6B);
    check("u_b2", rx_data[2], 8'h7C);
    check("u_l1", rx_last[1], 0);
    check("u_l2", rx_last[2], 1);
    check("u_cmds", cmd_n, 1);
    finish_bus();

    // NACK after byte 1 of a 4-byte burst
    clr();
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    data_tready = 1'b0;
    do_start(7'h50, 8'd4);
    cmd_handshake();
    tick();
    data_tready = 1'b1; missed_ack = 1'b1;
    tick();
    missed_ack = 1'b0;
    check("k_err", err, 1);
    check("k_busy", busy, 1);
    check("k_tvalid", data_tvalid, 0);
    tick(); tick(); tick();
    check("k_pops", pop_n, 1);
    check("k_rx", rx_n, 1);
    check("k_b0", rx_data[0], 8'hD1);
    check("k_fifo_left", 32'(wr_ptr - rd_ptr), 3);
    finish_bus();
    check("k_err_sticky", err, 1);
    clr();
    do_start(7'h51, 8'd3);
    check("k_err_cleared", err, 0);
    cmd_handshake();
    wait_rx(3);
    check("k_b1", rx_data[0], 8'hD2);
    check("k_b2", rx_data[1], 8'hD3);
    check("k_b3", rx_data[2], 8'hD4);
    check("k_last", rx_last[2], 1);
    finish_bus();

    // Reset mid-DATA
    clr();
    push(8'hE1); push(8'hE2); push(8'hE3);
    data_tready = 1'b0;
    do_start(7'h60, 8'd3);
    cmd_handshake();
    tick();
    check("r_tvalid_before", data_tvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("r_busy", busy, 0);
    check("r_tvalid", data_tvalid, 0);
    check("r_tdata", data_tdata, 0);
    check("r_tlast", data_tlast, 0);
    check("r_cmd_valid", cmd_valid, 0);
    check("r_fifo_next", fifo_next, 0);
    check("r_addr", cmd_address, 0);
    check("r_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    stall_prev = 1'b0;
    check("r_fifo_untouched", 32'(wr_ptr - rd_ptr), 2);
    clr();
    data_tready = 1'b1;
    do_start(7'h61, 8'd2);
    cmd_handshake();
    wait_rx(2);
    check("r_cmd_addr", cmd_addr_seen, 7'h61);
    check("r_b0", rx_data[0], 8'hE2);
    check("r_b1", rx_data[1], 8'hE3);
    check("r_l1", rx_last[1], 1);
    finish_bus();
    check("r_err_end", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_tx_sequencer.md
# i2c_tx_sequencer

Control stage between the I2C send-buffer `fifo` and `i2c_master`. It is the upstream feeder of the master's AXI-stream command and data channels and replaces the temporary button-driven start and always-valid wiring. On a start request it issues one write-multiple command to a 7-bit device address. It then streams exactly `len` bytes from the FIFO, asserts `tlast` on the final byte, and waits for the bus to go idle before reporting done or error.

## Interface
Parameters:
- `LenWidth`, default 8, width of the burst length; maximum burst is 2^LenWidth-1 bytes.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start` in 1: one-cycle request to begin a burst.
- `dev_addr` in 7: target address, captured at accepted `start`.
- `len` in LenWidth: byte count, captured at accepted `start`.
- `fifo_data` in 8: FIFO head byte (combinational).
- `fifo_have_next` in 1: FIFO non-empty.
- `fifo_next` out 1: pop strobe; the head is consumed this cycle.
- `cmd_address` out 7: to `s_axis_cmd_address`.
- `cmd_valid` out 1: to `s_axis_cmd_valid`.
- `cmd_write_multiple` out 1: to `s_axis_cmd_write_multiple`.
- `cmd_ready` in 1: from `s_axis_cmd_ready`.
- `data_tdata` out 8: to `s_axis_data_tdata`.
- `data_tvalid` out 1: to `s_axis_data_tvalid`.
- `data_tlast` out 1: to `s_axis_data_tlast`.
- `data_tready` in 1: from `s_axis_data_tready`.
- `i2c_busy` in 1: from the master's `busy`.
- `missed_ack` in 1: from the master's `missed_ack`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a burst ends, whether OK or in error.
- `err` out 1: sticky error; cleared at the next accepted `start`.

## Operation
States: IDLE, CMD, DATA, WAIT_DONE.

IDLE:
- `start` with `len`!=0 is accepted: capture `dev_addr` and `len` into `addr_q` and `rem_q`, clear `err`, go to CMD.
- `start` with `len`==0 is ignored. There is no `done` pulse and no state change.

CMD:
- `cmd_valid`=1 and `cmd_write_multiple`=1; `cmd_address`=`addr_q`.
- On `cmd_valid`&`cmd_ready`, go to DATA. `cmd_valid` stays stable until the handshake.

DATA, single-entry output buffer (`buf_q`, `buf_v`, `last_q`):
- Load condition: `rem_q`!=0 && `fifo_have_next` && (!`buf_v` || (`data_tready` && !`last_q`)).
- On load: `fifo_next`=1, `buf_q`<=`fifo_data`, `buf_v`<=1, `last_q`<=(`rem_q`==1), `rem_q`<=`rem_q`-1.
- `data_tvalid`=`buf_v`, `data_tdata`=`buf_q`, `data_tlast`=`last_q`. All three are stable while `tvalid` is high and `tready` is low.
- On a handshake without a load, `buf_v`<=0.
- A handshake with `last_q`=1 goes to WAIT_DONE.
- FIFO empty: `tvalid` goes low and the block stalls indefinitely. There is no timeout.
- `missed_ack`=1 in CMD or DATA: set `err`, clear `buf_v`, go to WAIT_DONE. Unsent bytes stay in the FIFO; they are not flushed.

WAIT_DONE:
- `fifo_next`=0, `cmd_valid`=0, `tvalid`=0.
- When `i2c_busy`=0, pulse `done` and go to IDLE.
- `missed_ack` in this state also sets `err`.

Other rules:
- `fifo_next` is never asserted outside DATA and never when `fifo_have_next`=0.
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE; `fifo_next`, `cmd_valid`, `cmd_write_multiple`, `data_tvalid`, `data_tlast`, `busy`, `done`, `err` all 0; `cmd_address`, `data_tdata` 0; `rem_q` 0.
- Start to command: `start` accepted at edge N; `cmd_valid`=1 and `busy`=1 from cycle N+1.
- First byte latency: command handshake at edge M; earliest `fifo_next` in cycle M+1; `data_tvalid` in M+2.
- Throughput: with `tready` held high and the FIFO non-empty, one byte per cycle.
- `rem_q` never underflows; `LenWidth`-bit arithmetic.
- `done` is high for exactly one cycle; `busy` falls in the same cycle `done` is high is not required, `busy` drops the cycle after `done`.
- Simultaneous `missed_ack` and final handshake: `err` is set, and the block goes to WAIT_DONE.
- Reset asserted mid-burst: the block returns to IDLE immediately and the buffered byte is lost. The FIFO is not touched.

## Test plan
- Normal burst: FIFO holds A1 B2 C3; `start`, `dev_addr`=0x27, `len`=3; `cmd_ready` after 2 cycles; `tready` always high. Required: one command to 0x27 with `write_multiple`=1; bytes A1,B2,C3 with `tlast` only on C3; exactly 3 `fifo_next` pulses; `done` once after `i2c_busy` falls; `err`=0.
- Backpressure: `len`=2 with `tready` toggling 1 cycle high, 3 cycles low. Required: `tdata`/`tlast` stable while stalled; no extra pops.
- Underflow stall: `len`=3 with only 1 byte in the FIFO; push 2 more bytes 20 cycles later. Required: `tvalid`=0 during the gap, then the burst completes with `tlast` on byte 3.
- Zero length and busy start: `start` with `len`=0 produces no `busy` and no `done`. A `start` mid-burst is ignored and the captured address is unchanged.
- NACK: `missed_ack` pulse after byte 1 of a 4-byte burst. Required: `err`=1, no further pops, 3 bytes left in the FIFO, `done` pulse, `err` cleared by the next `start`.
- Reset mid-DATA: all outputs take their reset values asynchronously, and the next `start` runs cleanly.
